// File: rtl/logic_pkg.sv
// logic_pkg: shared definitions for the ALU sequencer.
//   - 4-bit op code constants driven on ALUOp
//   - class-decode helpers (is_shift, is_branch, is_arith)
//   - sequencer FSM state enum
//   - NOP command constant (also the idle value of ALUOp)
package logic_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_XOR   = 4'h3;
  localparam logic [3:0] OP_SLT   = 4'h4;
  localparam logic [3:0] OP_SLL   = 4'h5;
  localparam logic [3:0] OP_SRL   = 4'h6;
  localparam logic [3:0] OP_SRA   = 4'h7;
  localparam logic [3:0] OP_SLLV  = 4'h8;
  localparam logic [3:0] OP_SRAV  = 4'h9;
  localparam logic [3:0] OP_BEQ   = 4'hA;
  localparam logic [3:0] OP_BNE   = 4'hB;
  localparam logic [3:0] OP_BLE   = 4'hC;
  localparam logic [3:0] OP_BGT   = 4'hD;
  localparam logic [3:0] OP_PASSA = 4'hE;
  localparam logic [3:0] OP_NOP   = 4'hF;

  // Value driven on ALUOp whenever no operation is in flight.
  localparam logic [3:0] ALUOP_NOP = OP_NOP;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    SHIFT   = 3'd2,
    CAPTURE = 3'd3,
    RESP    = 3'd4
  } seq_state_t;

  // Shift class needs separate load and shift cycles on the clocked shifter.
  function automatic logic is_shift(input logic [3:0] op);
    case (op)
      OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRAV: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  function automatic logic is_branch(input logic [3:0] op);
    case (op)
      OP_BEQ, OP_BNE, OP_BLE, OP_BGT: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  // Only ADD and SUB can raise a trappable overflow.
  function automatic logic is_arith(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB: return 1'b1;
      default:        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_stats.sv
// alu_seq_stats: two saturating event counters for the ALU sequencer.
// Only compiled when ALU_SEQ_STATS_EN is defined.
// Ports:
//   clk, reset      - clock, async active-high reset (clears counters)
//   inc_ops         - one pulse per accepted request
//   inc_ovf         - one pulse per capture with OVERFLOW high
//   stat_ops        - accepted-request count (saturates at all-ones)
//   stat_ovf        - overflow-capture count (saturates at all-ones)
`ifdef ALU_SEQ_STATS_EN
module alu_seq_stats #(
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc_ops,
  input  logic              inc_ovf,
  output logic [STAT_W-1:0] stat_ops,
  output logic [STAT_W-1:0] stat_ovf
);

  localparam logic [STAT_W-1:0] SAT_MAX = {STAT_W{1'b1}};
  localparam logic [STAT_W-1:0] ONE     = STAT_W'(1);

  // Saturating counters: hold at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_ops <= '0;
      stat_ovf <= '0;
    end else begin
      if (inc_ops && (stat_ops != SAT_MAX)) begin
        stat_ops <= stat_ops + ONE;
      end
      if (inc_ovf && (stat_ovf != SAT_MAX)) begin
        stat_ovf <= stat_ovf + ONE;
      end
    end
  end

endmodule
`endif

// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one decoded ALU request at a time, drives ALUOp for
// the cycles the op needs (shift ops get extra load/shift cycles), captures
// ALUOut and status flags into a held response for the main control FSM.
// Optional statistics counters are enabled by defining ALU_SEQ_STATS_EN.
// Ports:
//   clk, reset                  - clock, async active-high reset
//   req_valid/req_ready         - request handshake (ready only in IDLE)
//   req_op, req_trap_ovf        - op code and overflow-trap enable
//   ALUOp                       - command to the logic unit (NOP when idle)
//   ALUOut, OVERFLOW, ZERO,
//   SPECIAL, Update_UC          - logic unit result and status
//   rsp_valid/rsp_ready         - response handshake
//   rsp_result, rsp_zero, rsp_special, rsp_branch_taken,
//   rsp_ovf_exc, rsp_wr_en      - captured response
//   stat_ops, stat_ovf          - counters (ALU_SEQ_STATS_EN only)
module alu_sequencer
  import logic_pkg::*;
#(
  parameter int SHIFT_LAT = 2,
  parameter int STAT_W    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic        req_trap_ovf,
  output logic [3:0]  ALUOp,
  input  logic [31:0] ALUOut,
  input  logic        OVERFLOW,
  input  logic        ZERO,
  input  logic        SPECIAL,
  input  logic        Update_UC,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_special,
  output logic        rsp_branch_taken,
  output logic        rsp_ovf_exc,
  output logic        rsp_wr_en
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_ops,
  output logic [STAT_W-1:0] stat_ovf
`endif
);

  // Counter preload: ISSUE and CAPTURE each take one ALUOp cycle, so SHIFT
  // lasts SHIFT_LAT-1 cycles.
  localparam logic [2:0] SHIFT_LOAD = 3'(SHIFT_LAT - 1);

  seq_state_t state;
  logic [3:0] op_q;
  logic       trap_q;
  logic [2:0] shift_cnt;
  logic       accept;
  logic       cap_ovf_exc;
  logic       cap_branch;
  logic       cap_wr_en;

  assign accept = req_valid && req_ready;

  // Response decode from the latched op and the live logic-unit status.
  always_comb begin
    cap_ovf_exc = 1'b0;
    cap_branch  = 1'b0;
    cap_wr_en   = 1'b0;
    if (OVERFLOW && trap_q && is_arith(op_q)) begin
      cap_ovf_exc = 1'b1;
    end else begin
      cap_ovf_exc = 1'b0;
    end
    if (is_branch(op_q)) begin
      cap_branch = Update_UC;
    end else begin
      cap_branch = 1'b0;
    end
    if (is_branch(op_q) || (op_q == OP_NOP) || cap_ovf_exc) begin
      cap_wr_en = 1'b0;
    end else begin
      cap_wr_en = 1'b1;
    end
  end

  // Sequencer FSM with registered ALUOp, handshake and response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      op_q             <= OP_NOP;
      trap_q           <= 1'b0;
      shift_cnt        <= 3'd0;
      ALUOp            <= ALUOP_NOP;
      req_ready        <= 1'b1;
      rsp_valid        <= 1'b0;
      rsp_result       <= 32'h0000_0000;
      rsp_zero         <= 1'b0;
      rsp_special      <= 1'b0;
      rsp_branch_taken <= 1'b0;
      rsp_ovf_exc      <= 1'b0;
      rsp_wr_en        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q      <= req_op;
            trap_q    <= req_trap_ovf;
            ALUOp     <= req_op;
            req_ready <= 1'b0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (is_shift(op_q)) begin
            shift_cnt <= SHIFT_LOAD;
            state     <= SHIFT;
          end else begin
            state <= CAPTURE;
          end
        end
        SHIFT: begin
          shift_cnt <= shift_cnt - 3'd1;
          // Leave when the counter is about to hit zero (<= also guards 0).
          if (shift_cnt <= 3'd1) begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          rsp_valid        <= 1'b1;
          rsp_result       <= ALUOut;
          rsp_zero         <= ZERO;
          rsp_special      <= SPECIAL;
          rsp_branch_taken <= cap_branch;
          rsp_ovf_exc      <= cap_ovf_exc;
          rsp_wr_en        <= cap_wr_en;
          ALUOp            <= ALUOP_NOP;
          state            <= RESP;
        end
        RESP: begin
          // Ready rises only after the handshake, so no same-cycle accept.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          ALUOp     <= ALUOP_NOP;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          shift_cnt <= 3'd0;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_STATS_EN
  alu_seq_stats #(
    .STAT_W (STAT_W)
  ) u_stats (
    .clk      (clk),
    .reset    (reset),
    .inc_ops  (accept),
    .inc_ovf  ((state == CAPTURE) && OVERFLOW),
    .stat_ops (stat_ops),
    .stat_ovf (stat_ovf)
  );
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer (default SHIFT_LAT=2).
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic        req_trap_ovf;
  logic [3:0]  ALUOp;
  logic [31:0] ALUOut;
  logic        OVERFLOW, ZERO, SPECIAL, Update_UC;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_special, rsp_branch_taken, rsp_ovf_exc, rsp_wr_en;
`ifdef ALU_SEQ_STATS_EN
  logic [15:0] stat_ops, stat_ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_op           (req_op),
    .req_trap_ovf     (req_trap_ovf),
    .ALUOp            (ALUOp),
    .ALUOut           (ALUOut),
    .OVERFLOW         (OVERFLOW),
    .ZERO             (ZERO),
    .SPECIAL          (SPECIAL),
    .Update_UC        (Update_UC),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_result       (rsp_result),
    .rsp_zero         (rsp_zero),
    .rsp_special      (rsp_special),
    .rsp_branch_taken (rsp_branch_taken),
    .rsp_ovf_exc      (rsp_ovf_exc),
    .rsp_wr_en        (rsp_wr_en)
`ifdef ALU_SEQ_STATS_EN
    ,
    .stat_ops         (stat_ops),
    .stat_ovf         (stat_ovf)
`endif
  );

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic        trap;
    logic [31:0] alu_out;
    logic        ovf;
    logic        zero;
    logic        special;
    logic        upd;
    logic        e_branch;
    logic        e_ovf_exc;
    logic        e_wr;
    int          lat;      // cycle (after accept) where rsp_valid first reads 1
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Real logic-unit values, or their complement as decoys outside CAPTURE.
  task automatic drive_lu(input vec_t v, input logic real_vals);
    if (real_vals) begin
      ALUOut = v.alu_out; OVERFLOW = v.ovf; ZERO = v.zero;
      SPECIAL = v.special; Update_UC = v.upd;
    end else begin
      ALUOut = ~v.alu_out; OVERFLOW = ~v.ovf; ZERO = ~v.zero;
      SPECIAL = ~v.special; Update_UC = ~v.upd;
    end
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    chk({v.name, " req_ready idle"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = v.op; req_trap_ovf = v.trap;
    drive_lu(v, 1'b0);
    @(posedge clk); #1;          // accept edge = cycle 0
    req_valid = 1'b0;
    for (int c = 1; c <= v.lat; c++) begin
      @(negedge clk);
      chk({v.name, " aluop"}, {28'd0, ALUOp}, (c < v.lat) ? {28'd0, v.op} : 32'hF);
      chk({v.name, " rsp_valid"}, {31'd0, rsp_valid}, (c >= v.lat) ? 32'd1 : 32'd0);
      chk({v.name, " req_ready busy"}, {31'd0, req_ready}, 32'd0);
      drive_lu(v, c == v.lat - 1);
    end
    chk({v.name, " result"}, rsp_result, v.alu_out);
    chk({v.name, " zero"}, {31'd0, rsp_zero}, {31'd0, v.zero});
    chk({v.name, " special"}, {31'd0, rsp_special}, {31'd0, v.special});
    chk({v.name, " branch"}, {31'd0, rsp_branch_taken}, {31'd0, v.e_branch});
    chk({v.name, " ovf_exc"}, {31'd0, rsp_ovf_exc}, {31'd0, v.e_ovf_exc});
    chk({v.name, " wr_en"}, {31'd0, rsp_wr_en}, {31'd0, v.e_wr});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({v.name, " rsp_valid drop"}, {31'd0, rsp_valid}, 32'd0);
    chk({v.name, " req_ready back"}, {31'd0, req_ready}, 32'd1);
  endtask

  logic [31:0] held;

  initial begin
    //          name     op    trap alu_out       ovf z  s  upd br exc wr lat
    vecs[0]  = '{"add_trap",   4'h0, 1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3};
    vecs[1]  = '{"add_notrap", 4'h0, 1'b0, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3};
    vecs[2]  = '{"sub",        4'h1, 1'b1, 32'h0000_0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3};
    vecs[3]  = '{"and_zero",   4'h2, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3};
    vecs[4]  = '{"xor_ovf",    4'h3, 1'b1, 32'hFFFF_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3};
    vecs[5]  = '{"slt",        4'h4, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3};
    vecs[6]  = '{"sll",        4'h5, 1'b0, 32'h0000_0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4};
    vecs[7]  = '{"sra",        4'h7, 1'b1, 32'hF000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4};
    vecs[8]  = '{"srav",       4'h9, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4};
    vecs[9]  = '{"beq",        4'hA, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3};
    vecs[10] = '{"bne",        4'hB, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3};
    vecs[11] = '{"bgt",        4'hD, 1'b1, 32'h0000_0007, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3};
    vecs[12] = '{"passa",      4'hE, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3};
    vecs[13] = '{"nop",        4'hF, 1'b1, 32'hAAAA_5555, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3};

    reset = 1'b1; req_valid = 1'b0; req_op = 4'h0; req_trap_ovf = 1'b0;
    rsp_ready = 1'b0; ALUOut = 32'h0; OVERFLOW = 1'b0; ZERO = 1'b0;
    SPECIAL = 1'b0; Update_UC = 1'b0;
    #12;
    chk("reset aluop", {28'd0, ALUOp}, 32'hF);
    chk("reset req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset rsp_result", rsp_result, 32'd0);
    chk("reset rsp_wr_en", {31'd0, rsp_wr_en}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      run_vec(vecs[i]);
    end

    // Backpressure: response held 5 cycles while a second request waits.
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'h0; req_trap_ovf = 1'b0;
    drive_lu(vecs[2], 1'b0);
    @(posedge clk); #1;
    req_op = 4'h1;               // second request (SUB) stays pending
    @(negedge clk);              // cycle 1
    @(negedge clk);              // cycle 2: capture
    ALUOut = 32'hCAFE_0001; OVERFLOW = 1'b0; ZERO = 1'b0; SPECIAL = 1'b0; Update_UC = 1'b0;
    @(negedge clk);              // cycle 3: RESP
    ALUOut = 32'h0BAD_0BAD;
    held = rsp_result;
    chk("bp result", held, 32'hCAFE_0001);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp hold valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp hold result", rsp_result, 32'hCAFE_0001);
      chk("bp hold req_ready", {31'd0, req_ready}, 32'd0);
      chk("bp hold aluop", {28'd0, ALUOp}, 32'hF);
    end
    rsp_ready = 1'b1;
    @(negedge clk);              // handshake edge passed, now IDLE
    rsp_ready = 1'b0;
    chk("bp after hs valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp after hs ready", {31'd0, req_ready}, 32'd1);
    chk("bp after hs aluop", {28'd0, ALUOp}, 32'hF);
    @(posedge clk); #1;          // second op accepted here
    req_valid = 1'b0;
    @(negedge clk);
    chk("bp second aluop", {28'd0, ALUOp}, 32'h1);
    chk("bp second req_ready", {31'd0, req_ready}, 32'd0);
    ALUOut = 32'h0000_0042;      // cycle 2: capture
    @(negedge clk);
    @(negedge clk);
    chk("bp second valid", {31'd0, rsp_valid}, 32'd1);
    chk("bp second result", rsp_result, 32'h0000_0042);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Reset in the middle of a shift discards it.
    req_valid = 1'b1; req_op = 4'h5; req_trap_ovf = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);              // cycle 1 ISSUE
    @(negedge clk);              // cycle 2 SHIFT
    chk("rst mid aluop pre", {28'd0, ALUOp}, 32'h5);
    reset = 1'b1;
    #1;
    chk("rst mid aluop", {28'd0, ALUOp}, 32'hF);
    chk("rst mid rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst mid req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    run_vec(vecs[2]);
    run_vec(vecs[1]);            // overflowing ADD, trap off: written back
    run_vec(vecs[3]);
`ifdef ALU_SEQ_STATS_EN
    chk("stat_ops", {16'd0, stat_ops}, 32'd3);
    chk("stat_ovf", {16'd0, stat_ovf}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
